// File: rtl/accel_lsu_port.sv
// Accelerator load/store port: one base+offset access at a time, issued as a single
// req/gnt/rvalid transaction on the data memory bus, answered with a one-cycle lsu_done.
module accel_lsu_port #(
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic [1:0]  lsu_type,
  input  logic [31:0] lsu_addr_base,
  input  logic [31:0] lsu_addr_offset,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] DATA_BYTE = 2'b00;
  localparam logic [1:0] DATA_HALF = 2'b01;
  localparam logic [1:0] DATA_WORD = 2'b10;
  localparam logic [7:0] CNT_LAST  = 8'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, RESP} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  ea_lo, ea_lo_n;
  logic [1:0]  typ, typ_n;
  logic        is_store, is_store_n;
  logic        done_n, err_n, req_n, we_n;
  logic [3:0]  be_n;
  logic [31:0] addr_n, wdata_n, rdata_n;

  logic [31:0] ea;
  logic        bad;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [31:0] rsh;
  logic [31:0] load_data;

  assign ea = lsu_addr_base + lsu_addr_offset;

  // request decode on the live inputs; only consumed in the IDLE acceptance cycle
  always_comb begin
    bad = (lsu_ren & lsu_wen) | (lsu_type == 2'b11) |
          ((lsu_type == DATA_HALF) & ea[0]) |
          ((lsu_type == DATA_WORD) & (ea[1:0] != 2'b00));
    case (lsu_type)
      DATA_BYTE: begin
        be_calc = 4'b0001 << ea[1:0];
        wd_calc = {4{lsu_wdata[7:0]}};
      end
      DATA_HALF: begin
        be_calc = 4'b0011 << ea[1:0];
        wd_calc = {2{lsu_wdata[15:0]}};
      end
      default: begin
        be_calc = 4'b1111;
        wd_calc = lsu_wdata;
      end
    endcase
  end

  always_comb begin
    rsh = mem_rdata >> {ea_lo, 3'b000};
    case (typ)
      DATA_BYTE: load_data = {24'h0, rsh[7:0]};
      DATA_HALF: load_data = {16'h0, rsh[15:0]};
      default:   load_data = rsh;
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ea_lo_n    = ea_lo;
    typ_n      = typ;
    is_store_n = is_store;
    done_n     = 1'b0;
    err_n      = 1'b0;
    rdata_n    = 32'h0;
    req_n      = mem_req;
    we_n       = mem_we;
    be_n       = mem_be;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    case (state)
      IDLE: begin
        if (lsu_ren | lsu_wen) begin
          ea_lo_n    = ea[1:0];
          typ_n      = lsu_type;
          is_store_n = lsu_wen;
          if (bad) begin
            state_n = RESP;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = REQ;
            cnt_n   = 8'h0;
            req_n   = 1'b1;
            we_n    = lsu_wen;
            be_n    = be_calc;
            addr_n  = {ea[31:2], 2'b00};
            wdata_n = wd_calc;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_n = WAIT_RV;
          req_n   = 1'b0;
          we_n    = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n = RESP;
          req_n   = 1'b0;
          we_n    = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WAIT_RV: begin
        if (mem_rvalid) begin
          state_n = RESP;
          done_n  = 1'b1;
          if (!is_store) rdata_n = load_data;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'h0;
      ea_lo     <= 2'b00;
      typ       <= 2'b00;
      is_store  <= 1'b0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ea_lo     <= ea_lo_n;
      typ       <= typ_n;
      is_store  <= is_store_n;
      lsu_done  <= done_n;
      lsu_err   <= err_n;
      lsu_rdata <= rdata_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_be    <= be_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
    end
  end

endmodule
